// File: rtl/apb_host_pkg.sv
// ---------------------------------------------------------------------------
// apb_host_pkg
// Shared definitions for the DES accelerator APB host and its slave:
// the 3-bit command opcode, the host FSM state encoding, the slave register
// addresses, and helpers that classify opcodes.
// ---------------------------------------------------------------------------
package apb_host_pkg;

  typedef enum logic [2:0] {
    OP_ENC     = 3'd0,
    OP_DEC     = 3'd1,
    OP_KEY     = 3'd2,
    OP_RST     = 3'd3,
    OP_READ    = 3'd4,
    OP_CHK_IN  = 3'd5,
    OP_CHK_OUT = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Slave register map; the opcode doubles as the register address.
  localparam logic [2:0] REG_ENC     = 3'd0;
  localparam logic [2:0] REG_DEC     = 3'd1;
  localparam logic [2:0] REG_KEY     = 3'd2;
  localparam logic [2:0] REG_RST     = 3'd3;
  localparam logic [2:0] REG_READ    = 3'd4;
  localparam logic [2:0] REG_CHK_IN  = 3'd5;
  localparam logic [2:0] REG_CHK_OUT = 3'd6;

  // Opcodes 0-3 are writes, 4-6 are reads.
  function automatic logic op_is_write(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Reserved opcode is never legal; once a key sequence has started only
  // KEY writes are allowed until the fourth one completes.
  function automatic logic op_is_legal(input logic [2:0] op, input logic [1:0] key_phase);
    return (op != OP_RSVD) && ((key_phase == 2'd0) || (op == OP_KEY));
  endfunction

endpackage

// File: rtl/apb_des_host.sv
// ---------------------------------------------------------------------------
// apb_des_host
// Turns single commands into APB transfers to the DES accelerator slave and
// returns one response per command. Illegal commands (reserved opcode, or a
// non-KEY op in the middle of a key sequence) are answered with an error
// without touching the bus.
//
// Optional feature: define APB_HOST_TIMEOUT_EN to abandon a transfer after
// TIMEOUT_CYCLES consecutive PREADY-low ACCESS cycles (error response).
//
// Ports
//   clk, n_rst              clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op, cmd_wdata payload
//   rsp_valid/rsp_ready     response handshake; rsp_rdata, rsp_err payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB requester outputs
//   PRDATA/PSLVERR/PREADY   APB completer inputs
//   key_phase               KEY writes done in the current 4-write sequence
//   busy                    FSM not idle
//
// state  | meaning
// IDLE   | ready for a command, bus idle
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY
// RESP   | response held until rsp_ready
// ---------------------------------------------------------------------------
module apb_des_host
  import apb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [2:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR,
  input  logic        PREADY,
  output logic [1:0]  key_phase,
  output logic        busy
);

  state_e      state_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [2:0]  paddr_q;
  logic [31:0] pwdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [1:0]  key_phase_q;

`ifdef APB_HOST_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      key_phase_q <= '0;
`ifdef APB_HOST_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (op_is_legal(cmd_op, key_phase_q)) begin
              state_q  <= ST_SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= op_is_write(cmd_op);
              paddr_q  <= cmd_op;
              pwdata_q <= op_is_write(cmd_op) ? cmd_wdata : 32'd0;
            end else begin
              state_q     <= ST_RESP;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_HOST_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end

        ST_ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? 32'd0 : PRDATA;
            rsp_err_q   <= PSLVERR;
            // A slave error still counts as a completed key write.
            if (paddr_q == REG_KEY) key_phase_q <= key_phase_q + 2'd1;
            state_q   <= ST_RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
          end
`ifdef APB_HOST_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Abandoned transfer: error response, key sequence not advanced.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign key_phase = key_phase_q;

endmodule

// File: tb/tb_apb_des_host.sv
// ---------------------------------------------------------------------------
// tb_apb_des_host
// Directed and random commands against apb_des_host. The issuing task
// predicts each response from the command rules and queues it; a bus
// responder checks every APB transfer against the queued transfer; a
// response monitor pops and compares whenever rsp_valid is presented.
// ---------------------------------------------------------------------------
module tb_apb_des_host;

`ifdef APB_HOST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'd0;
  logic        PSLVERR = 1'b0;
  logic        PREADY = 1'b1;
  logic [1:0]  key_phase;
  logic        busy;

  always #5 clk = ~clk;

  apb_des_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .PREADY(PREADY),
    .key_phase(key_phase), .busy(busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  kp;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
  } bus_t;

  rsp_t sb[$];
  bus_t bus_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_kp = 0;
  bit stall_mode = 1'b0;
  bit rr_rand = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  // Reference model: decides legality and the response from the command
  // rules, then offers the command and waits for acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] wd, input logic [31:0] prd,
                       input logic serr, input int waits, output int acc);
    rsp_t r;
    bus_t b;
    bit   legal;
    int   n;
    legal = (op != 3'd7) && (model_kp == 0 || op == 3'd2);
    b.addr = op;
    b.wr = (op < 3'd4);
    b.wdata = (op < 3'd4) ? wd : 32'd0;
    b.prdata = prd;
    b.slverr = serr;
    b.waits = waits;
    if (!legal) begin
      r.rdata = 32'd0; r.err = 1'b1; r.lat = 1;
    end else if (TMO > 0 && waits >= TMO) begin
      r.rdata = 32'd0; r.err = 1'b1; r.lat = 2 + TMO;
    end else begin
      r.rdata = b.wr ? 32'd0 : prd;
      r.err = serr;
      r.lat = 3 + waits;
      if (op == 3'd2) model_kp = (model_kp + 1) % 4;
    end
    r.kp = 2'(model_kp);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      fail("cmd_accept", "not_ready", "ready");
      cmd_valid = 1'b0;
      return;
    end
    if (legal) bus_q.push_back(b);
    r.acc = cyc;
    sb.push_back(r);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain", "pending", "empty");
  endtask

  // APB responder: checks every transfer against the expected one and
  // inserts the requested number of wait states.
  bus_t cur_b;
  bit   b_act = 1'b0;
  int   acc_cnt = 0;
  int   wleft = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      b_act = 1'b0;
      PREADY = 1'b1;
    end else if (PSEL && !PENABLE) begin
      if (bus_q.size() == 0) begin
        fail("unexpected_setup", "psel", "idle");
        b_act = 1'b0;
      end else begin
        cur_b = bus_q.pop_front();
        b_act = 1'b1;
        acc_cnt = 0;
        wleft = cur_b.waits;
        chk("setup_paddr", 64'(PADDR), 64'(cur_b.addr));
        chk("setup_pwrite", 64'(PWRITE), 64'(cur_b.wr));
        chk("setup_pwdata", 64'(PWDATA), 64'(cur_b.wdata));
        PRDATA = cur_b.prdata;
        PSLVERR = cur_b.slverr;
        PREADY = 1'b0;
      end
    end else if (PSEL && PENABLE) begin
      if (!b_act) begin
        fail("unexpected_access", "penable", "setup_first");
      end else begin
        acc_cnt++;
        chk("access_hold", 64'({PADDR, PWRITE, PWDATA}), 64'({cur_b.addr, cur_b.wr, cur_b.wdata}));
        PREADY = (wleft == 0);
        if (wleft > 0) wleft--;
      end
    end else begin
      if (b_act) begin
        chk("access_cycles", 64'(acc_cnt),
            64'((TMO > 0 && cur_b.waits >= TMO) ? TMO : cur_b.waits + 1));
        b_act = 1'b0;
      end
      chk("idle_bus", 64'({PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
      PREADY = 1'b1;
      PRDATA = $urandom;
    end
  end

  // Response monitor: rsp_ready is chosen first so the pop matches the
  // value the DUT samples at the next rising edge.
  rsp_t cur_r;
  bit   in_rsp = 1'b0;
  int   resp_cnt = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      in_rsp = 1'b0;
      resp_cnt = 0;
    end else begin
      if (stall_mode && rsp_valid && resp_cnt < 3) rsp_ready = 1'b0;
      else if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
      else rsp_ready = 1'b1;
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            fail("unexpected_rsp", "rsp_valid", "no_rsp");
          end else begin
            cur_r = sb[0];
            in_rsp = 1'b1;
            chk("rsp_latency", 64'(cyc - cur_r.acc), 64'(cur_r.lat));
          end
        end
        if (in_rsp) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(cur_r.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(cur_r.err));
          chk("rsp_key_phase", 64'(key_phase), 64'(cur_r.kp));
          chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
          resp_cnt++;
          if (rsp_ready) begin
            void'(sb.pop_front());
            in_rsp = 1'b0;
            resp_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n;
    logic [2:0] op;

    #3;
    chk("rst_bus", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("rst_key_phase", 64'(key_phase), 64'd0);
    chk("rst_ready_busy", 64'({cmd_ready, busy}), 64'h2);
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;

    // ENC then DEC back to back with rsp_ready high: 4-cycle spacing.
    rr_rand = 1'b0;
    issue(3'd0, 32'h01234567, 32'h0, 1'b0, 0, a1);
    issue(3'd1, 32'h89ABCDEF, 32'h0, 1'b0, 0, a2);
    chk("throughput", 64'(a2 - a1), 64'd4);
    drain();

    // Key sequence with a non-KEY op rejected in the middle.
    issue(3'd2, 32'h11111111, 32'h0, 1'b0, 0, a1);
    issue(3'd2, 32'h22222222, 32'h0, 1'b1, 0, a1);
    issue(3'd5, 32'h0, 32'h12345678, 1'b0, 0, a1);
    issue(3'd2, 32'h33333333, 32'h0, 1'b0, 1, a1);
    issue(3'd2, 32'h44444444, 32'h0, 1'b0, 0, a1);
    drain();
    chk("key_phase_wrap", 64'(key_phase), 64'd0);

    // Reads with and without slave error.
    issue(3'd4, 32'h5A5A5A5A, 32'hDEADBEEF, 1'b0, 0, a1);
    issue(3'd4, 32'h5A5A5A5A, 32'hDEADBEEF, 1'b1, 0, a1);
    drain();

    // Five wait states and a three-cycle response stall.
    stall_mode = 1'b1;
    issue(3'd4, 32'h0, 32'hCAFEF00D, 1'b0, 5, a1);
    drain();
    stall_mode = 1'b0;

    // Reserved opcode, then long waits (timeout boundary when enabled).
    issue(3'd7, 32'hFFFFFFFF, 32'h0, 1'b0, 0, a1);
    issue(3'd6, 32'h0, 32'h0BADF00D, 1'b0, 20, a1);
    issue(3'd5, 32'h0, 32'h600DCAFE, 1'b0, 15, a1);
`ifdef APB_HOST_TIMEOUT_EN
    issue(3'd2, 32'h77777777, 32'h0, 1'b0, 40, a1);
    issue(3'd4, 32'h0, 32'h13572468, 1'b0, 16, a1);
`endif
    drain();

    // Reset in the middle of an ACCESS with key_phase non-zero.
    issue(3'd2, 32'hA0A0A0A0, 32'h0, 1'b0, 0, a1);
    drain();
    issue(3'd2, 32'hB0B0B0B0, 32'h0, 1'b0, 10, a1);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(PSEL && PENABLE)) fail("reach_access", "no_access", "access");
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_bus", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
    chk("midrst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("midrst_key_phase", 64'(key_phase), 64'd0);
    chk("midrst_ready_busy", 64'({cmd_ready, busy}), 64'h2);
    sb.delete();
    bus_q.delete();
    model_kp = 0;
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;

    // Random traffic with random response back-pressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) < 3) ? 3'd2 : 3'($urandom_range(0, 7));
      issue(op, $urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), a1);
    end
    drain();
    chk("final_key_phase", 64'(key_phase), 64'(model_kp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
